// File: rtl/hid_report_scheduler.sv
// hid_report_scheduler: slot timing, motion residual accumulation and the
// USB IN endpoint handshake for the periodic HID report path.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for the next slot event
// S_LOAD     | one cycle: report fields latched, tick_1khz high
// S_WAIT_FMT | waiting up to 4 cycles for the formatter's rpt_valid
// S_SEND     | ep_send high until the endpoint accepts with ep_ready
// S_WAIT_ACK | waiting for the host ack; timeout retries or drops the frame
module hid_report_scheduler #(
  parameter int CLK_HZ      = 100000000,
  parameter int RATE_HZ     = 1000,
  parameter int ACK_TIMEOUT = 5000,
  parameter int MAX_RETRY   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              mv_valid,
  input  logic signed [15:0] mv_dx,
  input  logic signed [15:0] mv_dy,
  input  logic [1:0]        mv_buttons,
  input  logic [3:0]        safety_flags,
  output logic              tick_1khz,
  output logic signed [7:0] dx,
  output logic signed [7:0] dy,
  output logic [1:0]        buttons,
  output logic [3:0]        safety_out,
  output logic [7:0]        frame_id,
  input  logic              rpt_valid,
  output logic              ep_send,
  input  logic              ep_ready,
  input  logic              ep_ack,
  output logic [7:0]        overrun_cnt,
  output logic [7:0]        drop_cnt
);

  localparam int DIV    = CLK_HZ / RATE_HZ;
  localparam int SLOT_W = $clog2(DIV);
  localparam int TMR_W  = $clog2(ACK_TIMEOUT + 1);
  localparam int RTY_W  = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DIV - 1);
  localparam logic [TMR_W-1:0]  ACK_LOAD  = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [RTY_W-1:0]  RTY_MAX   = RTY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_FMT,
    S_SEND,
    S_WAIT_ACK
  } state_t;

  state_t             state;
  logic [SLOT_W-1:0]  slot_cnt;
  logic               slot_evt;
  logic [1:0]         fmt_tmr;
  logic [TMR_W-1:0]   ack_tmr;
  logic [RTY_W-1:0]   retry;
  logic signed [15:0] acc_x, acc_y;
  logic signed [15:0] add_x, add_y;
  logic signed [7:0]  sub_x, sub_y;
  logic signed [17:0] sum_x, sum_y;
  logic               halt;

  assign halt = safety_flags[3];

  function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
    if (v > 18'sd32767)       return 16'sh7fff;
    else if (v < -18'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

  function automatic logic signed [7:0] clamp127(input logic signed [15:0] v);
    if (v > 16'sd127)       return 8'sd127;
    else if (v < -16'sd127) return -8'sd127;
    else                    return v[7:0];
  endfunction

  // Slot counter: free-runs 0..DIV-1 while enabled, parked at 0 otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
    end else if (!enable || slot_cnt == SLOT_LAST) begin
      slot_cnt <= '0;
    end else begin
      slot_cnt <= slot_cnt + SLOT_W'(1);
    end
  end

  assign slot_evt = enable && (slot_cnt == SLOT_LAST);

  // Residual update: the emitted value (held in dx/dy) is only subtracted in LOAD,
  // so a sample landing in that same cycle stays in the residual
  always_comb begin
    add_x = (mv_valid && !halt) ? mv_dx : 16'sd0;
    add_y = (mv_valid && !halt) ? mv_dy : 16'sd0;
    sub_x = (state == S_LOAD) ? dx : 8'sd0;
    sub_y = (state == S_LOAD) ? dy : 8'sd0;
    sum_x = $signed({{2{acc_x[15]}}, acc_x}) + $signed({{2{add_x[15]}}, add_x})
          - $signed({{10{sub_x[7]}}, sub_x});
    sum_y = $signed({{2{acc_y[15]}}, acc_y}) + $signed({{2{add_y[15]}}, add_y})
          - $signed({{10{sub_y[7]}}, sub_y});
  end

  // Saturating accumulators; a halted report discards the whole residual
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_x <= '0;
      acc_y <= '0;
    end else if (state == S_LOAD && safety_out[3]) begin
      acc_x <= '0;
      acc_y <= '0;
    end else begin
      acc_x <= sat16(sum_x);
      acc_y <= sat16(sum_y);
    end
  end

  // Report sequencing FSM with registered handshake outputs and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      tick_1khz   <= 1'b0;
      dx          <= '0;
      dy          <= '0;
      buttons     <= '0;
      safety_out  <= '0;
      frame_id    <= '0;
      ep_send     <= 1'b0;
      overrun_cnt <= '0;
      drop_cnt    <= '0;
      fmt_tmr     <= '0;
      ack_tmr     <= '0;
      retry       <= '0;
    end else begin
      tick_1khz <= 1'b0;
      if (slot_evt && state != S_IDLE && overrun_cnt != 8'hff) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end
      case (state)
        S_IDLE: begin
          if (slot_evt) begin
            state      <= S_LOAD;
            tick_1khz  <= 1'b1;
            dx         <= halt ? 8'sd0 : clamp127(acc_x);
            dy         <= halt ? 8'sd0 : clamp127(acc_y);
            buttons    <= halt ? 2'b00 : mv_buttons;
            safety_out <= safety_flags;
            frame_id   <= frame_id + 8'd1;
            retry      <= '0;
          end
        end
        S_LOAD: begin
          state   <= S_WAIT_FMT;
          fmt_tmr <= 2'd3;
        end
        S_WAIT_FMT: begin
          if (rpt_valid) begin
            state   <= S_SEND;
            ep_send <= 1'b1;
          end else if (fmt_tmr == 2'd0) begin
            state <= S_IDLE;
            if (drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
          end else begin
            fmt_tmr <= fmt_tmr - 2'd1;
          end
        end
        S_SEND: begin
          if (ep_ready) begin
            state   <= S_WAIT_ACK;
            ep_send <= 1'b0;
            ack_tmr <= ACK_LOAD;
          end
        end
        S_WAIT_ACK: begin
          // ACK_TIMEOUT ack-less cycles in this state trigger the retry decision
          if (ep_ack) begin
            state <= S_IDLE;
          end else if (ack_tmr == '0) begin
            if (retry < RTY_MAX) begin
              retry   <= retry + RTY_W'(1);
              state   <= S_SEND;
              ep_send <= 1'b1;
            end else begin
              state <= S_IDLE;
              if (drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
            end
          end else begin
            ack_tmr <= ack_tmr - TMR_W'(1);
          end
        end
        default: begin
          state   <= S_IDLE;
          ep_send <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hid_report_scheduler.sv
// Bench for hid_report_scheduler: scoreboarded report contents plus directed
// checks of handshake timing, retry, overrun, halt, timeout, reset and wrap.
module tb_hid_report_scheduler;

  localparam int CLK_HZ      = 20000;
  localparam int RATE_HZ     = 1000;
  localparam int ACK_TIMEOUT = 10;
  localparam int MAX_RETRY   = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic              mv_valid;
  logic signed [15:0] mv_dx, mv_dy;
  logic [1:0]        mv_buttons;
  logic [3:0]        safety_flags;
  logic              tick_1khz;
  logic signed [7:0] dx, dy;
  logic [1:0]        buttons;
  logic [3:0]        safety_out;
  logic [7:0]        frame_id;
  logic              rpt_valid;
  logic              ep_send;
  logic              ep_ready;
  logic              ep_ack;
  logic [7:0]        overrun_cnt, drop_cnt;

  hid_report_scheduler #(
    .CLK_HZ(CLK_HZ), .RATE_HZ(RATE_HZ), .ACK_TIMEOUT(ACK_TIMEOUT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mv_valid(mv_valid),
    .mv_dx(mv_dx), .mv_dy(mv_dy), .mv_buttons(mv_buttons), .safety_flags(safety_flags),
    .tick_1khz(tick_1khz), .dx(dx), .dy(dy), .buttons(buttons), .safety_out(safety_out),
    .frame_id(frame_id), .rpt_valid(rpt_valid), .ep_send(ep_send), .ep_ready(ep_ready),
    .ep_ack(ep_ack), .overrun_cnt(overrun_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] dx;
    logic [7:0] dy;
    logic [1:0] btn;
    logic [3:0] saf;
    logic [7:0] fid;
  } rpt_t;

  rpt_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   ticks  = 0;

  // responder configuration and observations
  bit   rpt_en      = 1'b1;
  int   ready_delay = 0;
  int   ack_delay   = 3;
  bit   ack_never   = 1'b0;
  int   send_cnt    = 0;
  int   cyc         = 0;
  int   last_ready  = -1;
  int   gaps[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int edx, input int edy, input int ebtn, input int esaf, input int efid);
    rpt_t e;
    e.dx  = 8'(edx);
    e.dy  = 8'(edy);
    e.btn = 2'(ebtn);
    e.saf = 4'(esaf);
    e.fid = 8'(efid);
    exp_q.push_back(e);
  endtask

  task automatic sample(input int sx, input int sy);
    mv_valid = 1'b1;
    mv_dx    = 16'(sx);
    mv_dy    = 16'(sy);
    cyc_wait(1);
    mv_valid = 1'b0;
  endtask

  task automatic wait_ticks(input int target, input int bound, input string name);
    int n;
    n = 0;
    while (ticks < target && n < bound) begin
      cyc_wait(1);
      n++;
    end
    check(name, ticks, target);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tick"}, int'(tick_1khz), 0);
    check({tag, "_ep_send"}, int'(ep_send), 0);
    check({tag, "_dx"}, int'(dx), 0);
    check({tag, "_dy"}, int'(dy), 0);
    check({tag, "_buttons"}, int'(buttons), 0);
    check({tag, "_safety_out"}, int'(safety_out), 0);
    check({tag, "_frame_id"}, int'(frame_id), 0);
    check({tag, "_overrun"}, int'(overrun_cnt), 0);
    check({tag, "_drop"}, int'(drop_cnt), 0);
  endtask

  // Monitor: every formatter load strobe pops and compares one expected report
  initial begin
    rpt_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tick_1khz === 1'b1) begin
        ticks++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_tick: got frame_id=%0d, required no tick", frame_id);
        end else begin
          e = exp_q.pop_front();
          if (dx !== $signed(e.dx) || dy !== $signed(e.dy) || buttons !== e.btn ||
              safety_out !== e.saf || frame_id !== e.fid) begin
            errors++;
            $display("FAIL report: got dx=%0d dy=%0d btn=%0d saf=%0d fid=%0d, required dx=%0d dy=%0d btn=%0d saf=%0d fid=%0d",
                     dx, dy, buttons, safety_out, frame_id,
                     $signed(e.dx), $signed(e.dy), e.btn, e.saf, e.fid);
          end
        end
      end
    end
  end

  // Formatter / endpoint / host model reacting to DUT outputs each cycle
  initial begin
    bit tick_prev;
    int send_age;
    int ack_cnt;
    bit ack_arm;
    tick_prev = 1'b0;
    send_age  = 0;
    ack_cnt   = 0;
    ack_arm   = 1'b0;
    rpt_valid = 1'b0;
    ep_ready  = 1'b0;
    ep_ack    = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      rpt_valid = rpt_en && tick_prev;
      tick_prev = tick_1khz;
      ep_ack = 1'b0;
      if (ack_arm) begin
        ack_cnt--;
        if (ack_cnt <= 0) begin
          ep_ack  = 1'b1;
          ack_arm = 1'b0;
        end
      end
      if (ep_send === 1'b1) begin
        if (send_age == 0) begin
          send_cnt++;
          if (last_ready >= 0) gaps.push_back(cyc - last_ready);
        end
        ep_ready = (send_age >= ready_delay);
        if (ep_ready) begin
          last_ready = cyc;
          ack_cnt    = ack_delay;
          ack_arm    = !ack_never;
        end
        send_age++;
      end else begin
        send_age = 0;
        ep_ready = 1'b0;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  initial begin
    int n;
    rst_n        = 1'b0;
    enable       = 1'b0;
    mv_valid     = 1'b0;
    mv_dx        = '0;
    mv_dy        = '0;
    mv_buttons   = 2'b00;
    safety_flags = 4'b0000;
    cyc_wait(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    cyc_wait(3);

    // basic frame and first-slot latency
    mv_buttons = 2'b01;
    push(50, -30, 1, 0, 1);
    enable   = 1'b1;
    mv_valid = 1'b1;
    mv_dx    = 16'sd50;
    mv_dy    = -16'sd30;
    n = 0;
    do begin
      cyc_wait(1);
      mv_valid = 1'b0;
      n++;
    end while (tick_1khz !== 1'b1 && n < 40);
    check("first_tick_latency", n, 20);
    cyc_wait(12);
    enable = 1'b0;
    cyc_wait(5);
    check("basic_send_cnt", send_cnt, 1);
    check("basic_ep_send_idle", int'(ep_send), 0);
    check("basic_overrun", int'(overrun_cnt), 0);
    check("basic_drop", int'(drop_cnt), 0);

    // clamp and residual carry-over in both directions
    send_cnt   = 0;
    mv_buttons = 2'b10;
    for (int i = 0; i < 3; i++) sample(100, -100);
    push(127, -127, 2, 0, 2);
    push(127, -127, 2, 0, 3);
    push(46, -46, 2, 0, 4);
    push(0, 0, 2, 0, 5);
    enable = 1'b1;
    wait_ticks(5, 120, "clamp_ticks");
    enable = 1'b0;
    cyc_wait(10);
    check("clamp_send_cnt", send_cnt, 4);

    // retry exhaustion: no ack ever
    ack_never = 1'b1;
    sample(5, 0);
    push(5, 0, 2, 0, 6);
    enable = 1'b1;
    wait_ticks(6, 40, "retry_tick");
    enable = 1'b0;
    gaps.delete();
    send_cnt   = 0;
    last_ready = -1;
    cyc_wait(60);
    check("retry_send_cnt", send_cnt, MAX_RETRY + 1);
    check("retry_gap_count", gaps.size(), MAX_RETRY);
    foreach (gaps[i]) check("retry_gap", gaps[i], ACK_TIMEOUT + 1);
    check("retry_drop", int'(drop_cnt), 1);
    check("retry_overrun", int'(overrun_cnt), 0);
    check("retry_ep_send_idle", int'(ep_send), 0);
    ack_never = 1'b0;
    push(0, 0, 2, 0, 7);
    enable = 1'b1;
    wait_ticks(7, 40, "after_retry_tick");
    enable = 1'b0;
    cyc_wait(10);
    check("after_retry_drop", int'(drop_cnt), 1);

    // overrun: endpoint stalls across two slot events
    ready_delay = 50;
    sample(20, 0);
    push(20, 0, 2, 0, 8);
    enable = 1'b1;
    wait_ticks(8, 40, "overrun_tick");
    cyc_wait(5);
    sample(-7, 9);
    push(-7, 9, 2, 0, 9);
    cyc_wait(40);
    ready_delay = 0;
    wait_ticks(9, 60, "overrun_next_tick");
    enable = 1'b0;
    cyc_wait(10);
    check("overrun_cnt", int'(overrun_cnt), 2);
    check("overrun_drop", int'(drop_cnt), 1);

    // safety halt: residual and in-halt samples discarded
    mv_buttons = 2'b11;
    sample(80, 0);
    safety_flags = 4'b1000;
    push(0, 0, 0, 8, 10);
    enable = 1'b1;
    wait_ticks(10, 40, "halt_tick");
    enable = 1'b0;
    cyc_wait(2);
    sample(33, -12);
    cyc_wait(15);
    safety_flags = 4'b0000;
    push(0, 0, 3, 0, 11);
    enable = 1'b1;
    wait_ticks(11, 40, "post_halt_tick");
    enable = 1'b0;
    cyc_wait(10);

    // formatter never answers: frame dropped after 4 cycles, no send
    rpt_en   = 1'b0;
    send_cnt = 0;
    sample(3, 0);
    push(3, 0, 3, 0, 12);
    enable = 1'b1;
    wait_ticks(12, 40, "fmt_timeout_tick");
    enable = 1'b0;
    cyc_wait(8);
    check("fmt_timeout_drop", int'(drop_cnt), 2);
    check("fmt_timeout_no_send", send_cnt, 0);
    rpt_en = 1'b1;

    // reset in the middle of SEND
    ready_delay = 50;
    sample(-60, 0);
    push(-60, 0, 3, 0, 13);
    enable = 1'b1;
    wait_ticks(13, 40, "reset_tick");
    enable = 1'b0;
    n = 0;
    while (ep_send !== 1'b1 && n < 10) begin
      cyc_wait(1);
      n++;
    end
    check("reset_in_send", int'(ep_send), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    cyc_wait(3);
    ready_delay = 0;
    rst_n = 1'b1;
    cyc_wait(3);

    // 256 frames: frame_id wraps 255 -> 0
    for (int i = 1; i <= 256; i++) push(0, 0, 3, 0, i & 255);
    enable = 1'b1;
    wait_ticks(13 + 256, 256 * 20 + 60, "wrap_ticks");
    enable = 1'b0;
    cyc_wait(10);
    check("wrap_frame_id", int'(frame_id), 0);
    check("wrap_overrun", int'(overrun_cnt), 0);
    check("wrap_drop", int'(drop_cnt), 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hid_report_scheduler.md
# hid_report_scheduler

Sequencing controller for the 1 kHz HID report path. It generates the report-rate slot strobe and accumulates motion samples from the decoder into a saturating residual. At each slot it presents clamped dx/dy, buttons, safety flags and frame_id to the HID report formatter. It then drives the USB IN endpoint handshake, including acknowledge timeout, bounded retransmission, and overrun/drop accounting.

## Interface
- CLK_HZ, 100000000, core clock frequency.
- RATE_HZ, 1000, report rate; DIV = CLK_HZ/RATE_HZ cycles per slot (integer, ≥16).
- ACK_TIMEOUT, 5000, cycles to wait for ep_ack before a retry.
- MAX_RETRY, 3, retransmissions per frame before the frame is dropped.
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; low stops new slots.
- mv_valid  in  1  motion sample strobe.
- mv_dx, mv_dy  in  16 signed  motion deltas.
- mv_buttons  in  2  button levels.
- safety_flags  in  4  safety tier and flags; bit 3 = halt.
- tick_1khz  out  1  one-cycle formatter load strobe.
- dx, dy  out  8 signed  clamped report motion.
- buttons  out  2  report buttons.
- safety_out  out  4  safety flags latched at load.
- frame_id  out  8  report sequence number.
- rpt_valid  in  1  formatter report-ready strobe.
- ep_send  out  1  request endpoint transmit.
- ep_ready  in  1  endpoint accepted transmit.
- ep_ack  in  1  host acknowledged report.
- overrun_cnt  out  8  skipped slots, saturating at 255.
- drop_cnt  out  8  abandoned frames, saturating at 255.

## Operation
- **Slot counter:** counts 0..DIV-1 while enable=1 and wraps; slot event when count = DIV-1. When enable=0 the counter is held at 0; an in-flight transaction still completes.
- **Accumulators (acc_x, acc_y):**
  - 16-bit signed, saturating to [-32768, 32767].
  - Each cycle: acc_next = sat(acc − emitted + (mv_valid ? mv : 0)).
  - emitted is nonzero only in the LOAD cycle.
- **States:** IDLE, LOAD, WAIT_FMT, SEND, WAIT_ACK.
  - IDLE: slot event → LOAD. The slot event is ignored in every other state.
  - LOAD (1 cycle):
    - emit = clamp(acc, −127, +127); dx/dy ← emit; buttons ← mv_buttons; safety_out ← safety_flags.
    - frame_id ← frame_id+1 (wraps 255→0); tick_1khz=1 this cycle; retry count ← 0.
    - → WAIT_FMT.
  - WAIT_FMT: rpt_valid → SEND. No rpt_valid within 4 cycles → drop_cnt++, IDLE.
  - SEND: ep_send=1 until ep_ready=1 is sampled, then → WAIT_ACK with timer cleared.
  - WAIT_ACK:
    - ep_ack → IDLE.
    - Timer reaches ACK_TIMEOUT: if retry < MAX_RETRY then retry++ and → SEND (same report, no new tick); otherwise drop_cnt++ and → IDLE.
- **Overrun:** a slot event while not in IDLE → overrun_cnt++. Motion keeps accumulating, so no motion is lost.
- **Safety halt (safety_flags[3]=1):**
  - mv samples are ignored.
  - At LOAD: dx=dy=0, buttons=0, accumulators cleared to 0.
  - The report is still sent, so the host sees the halt flag.
- **ep_ack outside WAIT_ACK:** ignored.

## Timing
- **Reset:** all outputs and state are asynchronously cleared. IDLE, slot counter 0, accumulators 0, tick_1khz=0, ep_send=0, dx=dy=0, buttons=0, safety_out=0, frame_id=0, overrun_cnt=drop_cnt=0. Deassertion is synchronized externally; the first slot event occurs DIV cycles after the first enabled cycle.
- **Slot to tick:** slot event at cycle T (in IDLE) → LOAD at T+1. tick_1khz is high at T+1, with dx/dy/buttons/safety_out/frame_id already updated at the same edge and stable through T+1.
- **Send request:** rpt_valid at T+2 → ep_send high from T+3.
- **ep_send:** a registered output that is high exactly during SEND; it drops the cycle after ep_ready is sampled.
- **Sample in the LOAD cycle:** an mv_valid sample coinciding with LOAD is added to the residual, not to the emitted value.
- **Reset mid-transaction:** aborts immediately; no drop is counted.

## Test plan
Scenarios run with DIV=20 and ACK_TIMEOUT=10.
- **Basic frame:** reset, enable=1, one mv sample dx=+50, dy=−30 → first tick at cycle 20 with dx=50, dy=−30, frame_id=1. With rpt_valid next cycle, ep_ready immediately and ep_ack 3 cycles later → IDLE, counters remain 0.
- **Clamp and residual:** samples summing to dx=+300 → successive frames emit 127, 127, 46, then 0.
- **Retry exhaustion:** ep_ack never asserted, MAX_RETRY=3 → ep_send asserts 4 times, spaced 10 cycles after each ep_ready. drop_cnt=1, no extra tick, next frame_id increments normally.
- **Overrun:** ep_ready held low for 50 cycles → overrun_cnt=2 and accumulated motion is delivered in the next frame.
- **Halt:** safety_flags=4'b1000 with acc_x=+80 → report dx=0, safety_out=8, accumulator 0 afterwards. Samples arriving during halt are ignored.
- **Reset/wrap:** rst_n pulsed low during SEND → ep_send=0 and all outputs 0 asynchronously. A separate run of 256 frames shows frame_id wrapping from 255 to 0.
